// File: rtl/perceptron_mac_n.sv
// perceptron_mac_n: N-input perceptron with a sequential multiply-accumulate
// engine and an in-place perceptron learning rule applied on misclassification.
module perceptron_mac_n #(
    parameter int N_IN     = 4,
    parameter int WIDTH    = 8,
    parameter int W_WIDTH  = 8,
    parameter int LR_SHIFT = 0,
    localparam int ACC_W   = WIDTH + W_WIDTH + $clog2(N_IN + 1),
    localparam int AW      = $clog2(N_IN + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [N_IN*WIDTH-1:0]   X_i,
    input  logic                    train_i,
    input  logic                    target_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    Y_o,
    output logic [ACC_W-1:0]        acc_o,
    output logic                    upd_o,
    input  logic                    w_we_i,
    input  logic [AW-1:0]           w_addr_i,
    input  logic [W_WIDTH-1:0]      w_data_i
);
    localparam int KW = $clog2(N_IN);
    localparam int PW = WIDTH + W_WIDTH;
    localparam int SW = ((W_WIDTH > WIDTH) ? W_WIDTH : WIDTH) + 2;
    localparam logic signed [SW-1:0] C_WMAX = SW'((2 ** (W_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] C_WMIN = SW'(-(2 ** (W_WIDTH - 1)));
    localparam logic signed [SW-1:0] C_ONE  = SW'(1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_UPD, S_OUT} state_t;

    state_t                     r_state, w_next;
    logic signed [W_WIDTH-1:0]  r_w [N_IN];
    logic signed [W_WIDTH-1:0]  r_bias;
    logic signed [WIDTH-1:0]    r_x [N_IN];
    logic                       r_train, r_target, r_y, r_upd;
    logic signed [ACC_W-1:0]    r_acc;
    logic [KW-1:0]              r_k;

    logic                       w_idle, w_accept, w_wr, w_last, w_mis;
    logic signed [WIDTH-1:0]    w_xk, w_step;
    logic signed [W_WIDTH-1:0]  w_wk, w_bias_ld;
    logic signed [PW-1:0]       w_prod;
    logic signed [ACC_W-1:0]    w_acc_nxt;
    logic signed [SW-1:0]       w_wsum, w_bsum;

    function automatic logic signed [W_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        return (v > C_WMAX) ? W_WIDTH'(C_WMAX) : (v < C_WMIN) ? W_WIDTH'(C_WMIN) : W_WIDTH'(v);
    endfunction

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = w_idle & in_valid_i;
    assign w_wr        = w_idle & w_we_i;
    assign w_last      = (r_k == KW'(N_IN - 1));
    assign w_xk        = r_x[r_k];
    assign w_wk        = r_w[r_k];
    assign w_prod      = PW'(w_wk) * PW'(w_xk);
    assign w_acc_nxt   = r_acc + ACC_W'(w_prod);
    // Y != target reduces to sign bit == target since Y = !sign
    assign w_mis       = r_train & (w_acc_nxt[ACC_W-1] == r_target);
    assign w_step      = w_xk >>> LR_SHIFT;
    assign w_wsum      = SW'(w_wk) + (r_target ? SW'(w_step) : -SW'(w_step));
    assign w_bsum      = SW'(r_bias) + (r_target ? C_ONE : -C_ONE);
    // a bias write in the accept cycle must be seen by that sample
    assign w_bias_ld   = (w_wr && w_addr_i == AW'(N_IN)) ? w_data_i : r_bias;

    assign in_ready_o  = w_idle;
    assign out_valid_o = (r_state == S_OUT);
    assign acc_o       = r_acc;
    assign Y_o         = r_y;
    assign upd_o       = r_upd;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state: IDLE -> MAC -> (UPDATE) -> OUT -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MAC;
            S_MAC:   if (w_last) w_next = w_mis ? S_UPD : S_OUT;
            S_UPD:   if (w_last) w_next = S_OUT;
            S_OUT:   if (out_ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // weight/bias storage: host writes only while idle, learning updates one weight per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) r_w[i] <= '0;
            r_bias <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < N_IN; i++) if (w_addr_i == AW'(i)) r_w[i] <= w_data_i;
            if (w_addr_i == AW'(N_IN)) r_bias <= w_data_i;
        end else if (r_state == S_UPD) begin
            r_w[r_k] <= sat(w_wsum);
            if (w_last) r_bias <= sat(w_bsum);
        end
    end

    // sample latch, accumulator, index counter and held result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) r_x[i] <= '0;
            r_train  <= 1'b0;
            r_target <= 1'b0;
            r_acc    <= '0;
            r_k      <= '0;
            r_y      <= 1'b0;
            r_upd    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    for (int i = 0; i < N_IN; i++) r_x[i] <= X_i[i*WIDTH +: WIDTH];
                    r_train  <= train_i;
                    r_target <= target_i;
                    r_acc    <= ACC_W'(w_bias_ld);
                    r_k      <= '0;
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= w_last ? '0 : r_k + 1'b1;
                    if (w_last) begin
                        r_y   <= ~w_acc_nxt[ACC_W-1];
                        r_upd <= w_mis;
                    end
                end
                S_UPD:   r_k <= w_last ? '0 : r_k + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_perceptron_mac_n.sv
// tb_perceptron_mac_n: randomized and directed bench against a plain-arithmetic perceptron model
module tb_perceptron_mac_n;
    localparam int N  = 4;
    localparam int WD = 8;
    localparam int WW = 8;
    localparam int LR = 0;
    localparam int ACC_W = WD + WW + $clog2(N + 1);
    localparam int AW = $clog2(N + 1);

    logic clk = 0, reset = 0, in_valid_i = 0, train_i = 0, target_i = 0, out_ready_i = 1, w_we_i = 0;
    logic [N*WD-1:0] X_i = '0;
    logic [AW-1:0] w_addr_i = '0;
    logic [WW-1:0] w_data_i = '0;
    logic in_ready_o, out_valid_o, Y_o, upd_o;
    logic [ACC_W-1:0] acc_o;

    int checks = 0, errors = 0;
    int mw[N];
    int mb = 0;
    int exp_acc = 0;
    bit exp_y = 0, exp_upd = 0;
    int got_acc, got_lat;
    bit got_y, got_upd;

    perceptron_mac_n #(.N_IN(N), .WIDTH(WD), .W_WIDTH(WW), .LR_SHIFT(LR)) dut (
        .clk(clk), .reset(reset), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .X_i(X_i),
        .train_i(train_i), .target_i(target_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .Y_o(Y_o), .acc_o(acc_o), .upd_o(upd_o), .w_we_i(w_we_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        int hi = (1 << (WW - 1)) - 1;
        return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
    endfunction

    // every cycle a result is presented it must match the model and the engine must be busy
    always @(negedge clk) begin
        if (reset && out_valid_o) begin
            chk("acc_o", $signed(acc_o), exp_acc);
            chk("Y_o", Y_o, exp_y);
            chk("upd_o", upd_o, exp_upd);
            chk("ready_in_out", in_ready_o, 0);
        end
    end

    task automatic wr(input int a, input int d);
        @(posedge clk); #1;
        w_we_i = 1; w_addr_i = AW'(a); w_data_i = WW'(d);
        @(posedge clk); #1;
        w_we_i = 0;
        if (a < N) mw[a] = d;
        else if (a == N) mb = d;
    endtask

    task automatic run(input int x[N], input bit tr, input bit tg, input int hold,
                       input bit wr_out, input bit co_wr, input int co_data);
        int n, s;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) X_i[k*WD +: WD] = x[k][WD-1:0];
        train_i = tr; target_i = tg; in_valid_i = 1; out_ready_i = (hold == 0);
        if (co_wr) begin
            w_we_i = 1; w_addr_i = AW'(N); w_data_i = co_data[WW-1:0]; mb = co_data;
        end
        n = 0;
        @(negedge clk);
        while (!in_ready_o && n < 20) begin @(negedge clk); n++; end
        chk("accept", in_ready_o, 1);
        s = mb;
        for (int k = 0; k < N; k++) s += mw[k] * x[k];
        exp_acc = s; exp_y = (s >= 0); exp_upd = tr && (exp_y != tg);
        if (exp_upd) begin
            for (int k = 0; k < N; k++) mw[k] = sat(mw[k] + (tg ? 1 : -1) * (x[k] >>> LR));
            mb = sat(mb + (tg ? 1 : -1));
        end
        @(posedge clk); #1;
        in_valid_i = 0; w_we_i = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid_o && n < 40);
        got_lat = n;
        chk("latency", n, exp_upd ? 2 * N + 1 : N + 1);
        got_acc = $signed(acc_o); got_y = Y_o; got_upd = upd_o;
        for (int h = 0; h < hold; h++) begin
            if (wr_out && h == 0) begin w_we_i = 1; w_addr_i = '0; w_data_i = 8'd50; end
            @(negedge clk);
            w_we_i = 0;
            chk("held_valid", out_valid_o, 1);
            chk("busy_ready", in_ready_o, 0);
        end
        out_ready_i = 1;
        @(negedge clk);
        chk("valid_drop", out_valid_o, 0);
        chk("idle_ready", in_ready_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int x[N];
        int n;
        for (int k = 0; k < N; k++) mw[k] = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_acc", $signed(acc_o), 0);
        chk("rst_y", Y_o, 0);
        chk("rst_upd", upd_o, 0);
        chk("rst_ready", in_ready_o, 1);
        reset = 1;

        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4); wr(4, -10);
        x = '{1, 1, 1, 1};
        run(x, 0, 0, 0, 0, 0, 0);
        chk("t1_acc", got_acc, 0); chk("t1_y", got_y, 1); chk("t1_upd", got_upd, 0); chk("t1_lat", got_lat, 5);

        run(x, 0, 0, 0, 0, 1, -11);
        chk("t2_acc", got_acc, -1); chk("t2_y", got_y, 0);

        run(x, 0, 0, 3, 1, 0, 0);
        chk("t3_acc", got_acc, -1);
        run(x, 0, 0, 0, 0, 0, 0);
        chk("t6_out_write_dropped", got_acc, -1);

        for (int a = 0; a <= N; a++) wr(a, 0);
        x = '{10, -5, 0, 3};
        run(x, 1, 0, 0, 0, 0, 0);
        chk("t4_acc", got_acc, 0); chk("t4_y", got_y, 1); chk("t4_upd", got_upd, 1); chk("t4_lat", got_lat, 9);
        run(x, 0, 0, 0, 0, 0, 0);
        chk("t4_rerun_acc", got_acc, -135); chk("t4_rerun_y", got_y, 0); chk("t4_rerun_upd", got_upd, 0);

        wr(0, 127); wr(1, -128); wr(2, 0); wr(3, 0); wr(4, 0);
        x = '{10, 127, 0, 0};
        run(x, 1, 1, 0, 0, 0, 0);
        chk("t5_y", got_y, 0); chk("t5_upd", got_upd, 1);
        x = '{1, 1, 1, 1};
        run(x, 0, 0, 0, 0, 0, 0);
        chk("t5_readback", got_acc, 127);
        wr(7, 99);
        run(x, 0, 0, 0, 0, 0, 0);
        chk("bad_addr_ignored", got_acc, 127);

        repeat (40) begin
            if ($urandom_range(2) == 0) wr($urandom_range(7), int'($urandom_range(255)) - 128);
            for (int k = 0; k < N; k++) x[k] = int'($urandom_range(255)) - 128;
            run(x, 1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(2)), 0,
                $urandom_range(3) == 0, int'($urandom_range(255)) - 128);
        end

        x = '{5, 6, 7, 8};
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) X_i[k*WD +: WD] = x[k][WD-1:0];
        train_i = 1; in_valid_i = 1;
        @(negedge clk);
        chk("t6_accept", in_ready_o, 1);
        @(posedge clk); #1;
        in_valid_i = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        chk("t6_valid_async", out_valid_o, 0);
        chk("t6_acc_async", $signed(acc_o), 0);
        chk("t6_ready_async", in_ready_o, 1);
        for (int k = 0; k < N; k++) mw[k] = 0;
        mb = 0;
        @(negedge clk);
        reset = 1;
        n = 0;
        repeat (8) begin @(negedge clk); n += int'(out_valid_o); end
        chk("t6_no_stale", n, 0);
        chk("t6_ready_after", in_ready_o, 1);
        x = '{9, -3, 4, 100};
        run(x, 0, 0, 0, 0, 0, 0);
        chk("t6_zero_weights_acc", got_acc, 0); chk("t6_zero_weights_y", got_y, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
